// File: rtl/fir_pkg.sv
// Shared definitions for the FIR stream loader: default sizes, the loader
// state encoding and the counter-width helper.
package fir_pkg;

  localparam int W1_DEF      = 9;
  localparam int L_DEF       = 15;
  localparam int FIR_LAT_DEF = 1;

  // Width of a counter that must hold the values 0..L inclusive.
  localparam int CNT_W = $clog2(L_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } loader_state_t;

  function automatic int cnt_width(input int taps);
    return $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// L x W1 coefficient register file: one synchronous write port that drops
// out-of-range addresses, one combinational read port.
module fir_coef_bank #(
  parameter int W1 = 9,
  parameter int L  = 15,
  parameter int AW = $clog2(L)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W1-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [W1-1:0] rdata
);

  localparam logic [AW:0] L_W = (AW + 1)'(L);

  logic [W1-1:0] mem [L];

  // Coefficient write; addresses at or above L are silently dropped.
  // NOTE: the bank has no reset -- its contents are only meaningful after
  // software writes them, and resetting a register file costs a mux per bit.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < L_W)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_stream_loader.sv
// Writer side of the FIR load/run port set. Shifts the coefficient bank into
// the filter (load_x low, coef[L-1] first), optionally flushes the delay line,
// then streams valid/ready samples and flags warmed-up FIR outputs.
// Build option: define FIR_LOADER_FLUSH_EN to add the FLUSH state, which
// drives L zero samples after LOAD and pre-qualifies the first sample.
module fir_stream_loader
  import fir_pkg::*;
#(
  parameter int W1      = W1_DEF,
  parameter int L       = L_DEF,
  parameter int FIR_LAT = FIR_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [$clog2(L)-1:0] cfg_addr,
  input  logic [W1-1:0]        cfg_data,
  input  logic                 start,
  input  logic                 stop,
  output logic                 busy,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [W1-1:0]        s_data,
  output logic                 load_x,
  output logic [W1-1:0]        c_out,
  output logic [W1-1:0]        x_out,
  output logic                 y_valid
);

  localparam int AW = $clog2(L);
  localparam int CW = cnt_width(L);

  loader_state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [CW-1:0] warm, warm_d;
  logic          load_x_d, s_ready_d, busy_d;
  logic [W1-1:0] c_out_d, x_out_d;
  logic [AW-1:0] rd_addr;
  logic [W1-1:0] rd_data;
  logic          accept, launch, tok_clr;
  logic [FIR_LAT:0] tok;

  assign accept  = s_valid & s_ready;
  assign y_valid = tok[FIR_LAT];

  // Next coefficient to present: L-1 when entering LOAD, else one below the
  // index currently on c_out.
  assign rd_addr = (state == LOAD && cnt != '0) ? AW'(cnt - CW'(1)) : AW'(L - 1);

  fir_coef_bank #(.W1(W1), .L(L), .AW(AW)) u_bank (
    .clk   (clk),
    .we    (cfg_we && state == IDLE),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Next-state and next-output decode; stop beats start, start is only
  // honoured from IDLE or RUN.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    warm_d    = warm;
    load_x_d  = 1'b1;
    c_out_d   = '0;
    x_out_d   = '0;
    s_ready_d = 1'b0;
    launch    = 1'b0;
    tok_clr   = 1'b0;
    if (stop) begin
      state_d = IDLE;
      tok_clr = 1'b1;
    end else if (start && (state == IDLE || state == RUN)) begin
      state_d  = LOAD;
      cnt_d    = CW'(L - 1);
      warm_d   = '0;
      tok_clr  = 1'b1;
      load_x_d = 1'b0;
      c_out_d  = rd_data;
    end else begin
      case (state)
        IDLE: state_d = IDLE;
        LOAD: begin
          if (cnt == '0) begin
`ifdef FIR_LOADER_FLUSH_EN
            state_d = FLUSH;
            cnt_d   = CW'(L - 1);
`else
            state_d   = RUN;
            s_ready_d = 1'b1;
`endif
          end else begin
            cnt_d    = cnt - CW'(1);
            load_x_d = 1'b0;
            c_out_d  = rd_data;
          end
        end
`ifdef FIR_LOADER_FLUSH_EN
        FLUSH: begin
          if (cnt == '0) begin
            state_d   = RUN;
            s_ready_d = 1'b1;
            warm_d    = CW'(L);
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
`endif
        RUN: begin
          s_ready_d = 1'b1;
          if (accept) begin
            x_out_d = s_data;
            launch  = (warm >= CW'(L - 1));
            if (warm != CW'(L)) warm_d = warm + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      warm    <= '0;
      load_x  <= 1'b1;
      c_out   <= '0;
      x_out   <= '0;
      s_ready <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      warm    <= warm_d;
      load_x  <= load_x_d;
      c_out   <= c_out_d;
      x_out   <= x_out_d;
      s_ready <= s_ready_d;
      busy    <= busy_d;
    end
  end

  // Qualified-sample tokens travel FIR_LAT+1 stages; the last stage is y_valid.
  always_ff @(posedge clk) begin
    if (!reset || tok_clr) begin
      tok <= '0;
    end else begin
      tok <= {tok[FIR_LAT-1:0], launch};
    end
  end

endmodule

// File: tb/tb_fir_stream_loader.sv
// Directed self-checking bench for fir_stream_loader (W1=9, L=15, FIR_LAT=1).
// Works with or without FIR_LOADER_FLUSH_EN defined.
module tb_fir_stream_loader;

  localparam int W1 = 9;
  localparam int L  = 15;
  localparam int AW = $clog2(L);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [W1-1:0] cfg_data = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          s_valid = 1'b0;
  logic [W1-1:0] s_data = '0;
  logic          busy, s_ready, load_x, y_valid;
  logic [W1-1:0] c_out, x_out;

  int passed = 0;
  int total  = 0;

`ifdef FIR_LOADER_FLUSH_EN
  localparam bit FLUSH_MODE = 1'b1;
`else
  localparam bit FLUSH_MODE = 1'b0;
`endif

  fir_stream_loader #(.W1(W1), .L(L), .FIR_LAT(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .load_x   (load_x),
    .c_out    (c_out),
    .x_out    (x_out),
    .y_valid  (y_valid)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs then show the post-edge values.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int data);
    cfg_addr = AW'(addr);
    cfg_data = W1'(data);
    cfg_we   = 1'b1;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    total++; if ({load_x, busy, s_ready, y_valid} !== 4'b1000) $display("FAIL reset_flags: got %b want 1000", {load_x, busy, s_ready, y_valid}); else passed++;
    total++; if (c_out !== '0 || x_out !== '0) $display("FAIL reset_data: got c_out=%0d x_out=%0d want 0 0", c_out, x_out); else passed++;
    step();
    total++; if (busy !== 1'b0 || s_ready !== 1'b0) $display("FAIL idle_hold: got busy=%b s_ready=%b want 0 0", busy, s_ready); else passed++;
  endtask

  task automatic test_load();
    for (int i = 0; i < L; i++) write_coef(i, i + 1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < L; j++) begin
      total++;
      if (load_x !== 1'b0 || c_out !== W1'(L - j) || x_out !== '0 || busy !== 1'b1)
        $display("FAIL load_seq[%0d]: got load_x=%b c_out=%0d x_out=%0d busy=%b want 0 %0d 0 1", j, load_x, c_out, x_out, busy, L - j);
      else passed++;
      step();
    end
    total++; if (load_x !== 1'b1 || c_out !== '0) $display("FAIL load_end: got load_x=%b c_out=%0d want 1 0", load_x, c_out); else passed++;
`ifdef FIR_LOADER_FLUSH_EN
    for (int j = 0; j < L; j++) begin
      total++;
      if (x_out !== '0 || s_ready !== 1'b0 || load_x !== 1'b1 || busy !== 1'b1)
        $display("FAIL flush[%0d]: got x_out=%0d s_ready=%b load_x=%b busy=%b want 0 0 1 1", j, x_out, s_ready, load_x, busy);
      else passed++;
      step();
    end
`endif
    total++; if (s_ready !== 1'b1) $display("FAIL run_ready: got s_ready=%b want 1", s_ready); else passed++;
  endtask

  task automatic test_stream();
    logic exp_y;
    for (int n = 1; n <= 20; n++) begin
      s_valid = 1'b1;
      s_data  = W1'(n);
      step();
      // y_valid seen now belongs to sample n-1 (accepted one edge earlier).
      exp_y = (n > 1) && (FLUSH_MODE || (n - 1) >= L);
      total++; if (x_out !== W1'(n)) $display("FAIL stream_x[%0d]: got %0d want %0d", n, x_out, n); else passed++;
      total++; if (y_valid !== exp_y) $display("FAIL stream_y[%0d]: got %b want %b", n - 1, y_valid, exp_y); else passed++;
    end
    s_valid = 1'b0;
    s_data  = '0;
    step();
    total++; if (x_out !== '0 || y_valid !== 1'b1) $display("FAIL stream_tail: got x_out=%0d y_valid=%b want 0 1", x_out, y_valid); else passed++;
    step();
    total++; if (y_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", y_valid); else passed++;
  endtask

  task automatic test_gapped();
    logic prev_v = 1'b0;
    logic [W1-1:0] exp_x;
    for (int i = 0; i < 10; i++) begin
      s_valid = (i % 2 == 0);
      s_data  = W1'(40 + i);
      step();
      exp_x = s_valid ? W1'(40 + i) : '0;
      total++; if (x_out !== exp_x) $display("FAIL gap_x[%0d]: got %0d want %0d", i, x_out, exp_x); else passed++;
      total++; if (y_valid !== prev_v) $display("FAIL gap_y[%0d]: got %b want %b", i, y_valid, prev_v); else passed++;
      prev_v = s_valid;
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic test_cfg_ignore();
    // Write while running must be dropped; start mid-LOAD must be ignored.
    write_coef(3, 99);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < L; j++) begin
      if (j == 5) start = 1'b1;
      total++;
      if (load_x !== 1'b0 || c_out !== W1'(L - j))
        $display("FAIL reload_seq[%0d]: got load_x=%b c_out=%0d want 0 %0d", j, load_x, c_out, L - j);
      else passed++;
      step();
      start = 1'b0;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++; if ({busy, load_x, s_ready} !== 3'b010 || x_out !== '0) $display("FAIL stop_idle: got busy=%b load_x=%b s_ready=%b x_out=%0d want 0 1 0 0", busy, load_x, s_ready, x_out); else passed++;
    // Out-of-range address in IDLE must leave the bank untouched.
    write_coef(15, 77);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < L; j++) begin
      total++;
      if (c_out !== W1'(L - j)) $display("FAIL oor_seq[%0d]: got %0d want %0d", j, c_out, L - j); else passed++;
      step();
    end
  endtask

  task automatic test_stop_start();
    for (int b = 0; b < 3 * L && s_ready !== 1'b1; b++) step();
    total++; if (s_ready !== 1'b1) $display("FAIL run_timeout: got s_ready=%b want 1", s_ready); else passed++;
    s_valid = 1'b1;
    s_data  = W1'(5);
    stop    = 1'b1;
    start   = 1'b1;
    step();
    stop    = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    total++; if ({busy, load_x, s_ready} !== 3'b010 || x_out !== '0) $display("FAIL stop_start: got busy=%b load_x=%b s_ready=%b x_out=%0d want 0 1 0 0", busy, load_x, s_ready, x_out); else passed++;
    step();
    total++; if ({busy, load_x, y_valid} !== 3'b010) $display("FAIL stop_stay: got busy=%b load_x=%b y_valid=%b want 0 1 0", busy, load_x, y_valid); else passed++;
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    total++; if (load_x !== 1'b0 || c_out !== W1'(L - 2)) $display("FAIL mid_load: got load_x=%b c_out=%0d want 0 %0d", load_x, c_out, L - 2); else passed++;
    reset = 1'b0;
    step();
    reset = 1'b1;
    total++; if ({load_x, busy, s_ready, y_valid} !== 4'b1000) $display("FAIL mid_reset_flags: got %b want 1000", {load_x, busy, s_ready, y_valid}); else passed++;
    total++; if (c_out !== '0 || x_out !== '0) $display("FAIL mid_reset_data: got c_out=%0d x_out=%0d want 0 0", c_out, x_out); else passed++;
    step();
    total++; if (busy !== 1'b0) $display("FAIL post_reset_idle: got busy=%b want 0", busy); else passed++;
    // Bank survives reset.
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (c_out !== W1'(L)) $display("FAIL bank_kept0: got %0d want %0d", c_out, L); else passed++;
    step();
    total++; if (c_out !== W1'(L - 1)) $display("FAIL bank_kept1: got %0d want %0d", c_out, L - 1); else passed++;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load();
    test_stream();
    test_gapped();
    test_cfg_ignore();
    test_stop_start();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fir_stream_loader.md
# fir_stream_loader

Driver for the FIR filter's load/run interface, the writer side of its `Load_x`/`c_in`/`x_in` port set. It holds an L-entry coefficient bank written by a configuration port. On command it shifts the coefficients into the FIR with `load_x` low, optionally flushes the FIR delay line, then streams samples from a valid/ready source into the filter. It flags which FIR outputs are meaningful.

## Interface
- W1, 9, bit width of coefficients and samples
- L, 15, number of taps/coefficients
- FIR_LAT, 1, clock cycles from `x_out` to the matching FIR `y_out`; must be ≥1
- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  reset is synchronous and active-low; one clock
- cfg_we  in  1  coefficient bank write strobe
- cfg_addr  in  $clog2(L)  coefficient index; values ≥L are ignored
- cfg_data  in  W1  coefficient value
- start  in  1  begin load sequence (pulse)
- stop  in  1  return to IDLE (pulse)
- busy  out  1  high in every state except IDLE
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when `s_valid & s_ready`
- s_data  in  W1  sample value
- load_x  out  1  to FIR `Load_x`: 0 = coefficient shift, 1 = run
- c_out  out  W1  to FIR `c_in`
- x_out  out  W1  to FIR `x_in`
- y_valid  out  1  FIR `y_out` this cycle corresponds to a real, warmed-up sample

## Operation
- States: IDLE, LOAD, FLUSH (macro-dependent), RUN. All outputs registered.
- IDLE: `load_x`=1, `x_out`=0, `c_out`=0, `s_ready`=0. Writes with `cfg_we` are accepted only in IDLE and are ignored otherwise.
- `start` in IDLE or RUN → LOAD. `start` in LOAD or FLUSH is ignored. `stop` in any state → IDLE next cycle. `stop` wins over a simultaneous `start`.
- LOAD: L cycles with `load_x`=0. `c_out` presents coef[L-1] first and coef[0] last, with a down-counter as the index. `x_out`=0.
- After LOAD: go to FLUSH if the macro is enabled, otherwise go to RUN.
- RUN: `load_x`=1, `s_ready`=1. `x_out` = `s_data` of the accepted sample, or 0 in cycles with no valid sample. The FIR advances every cycle regardless.
- y_valid pipeline:
  - An accepted sample launches a token through a FIR_LAT+1-deep shift register.
  - Warm-up counter `warm` saturates at L and is cleared on entry to LOAD.
  - Without the macro, `y_valid` = token out AND (`warm` at token launch ≥ L-1).
  - `stop` or LOAD entry flushes all pending tokens.
- A write to the bank during RUN is not possible because writes are IDLE-only. A reload therefore uses the bank contents as of the last IDLE.

## Timing
- Reset (`reset`=0 at an edge): state IDLE; `load_x`=1; `c_out`=`x_out`=0; `busy`=`s_ready`=`y_valid`=0; counters 0. The coefficient bank is not reset.
- `start` sampled at edge T:
  - T+1..T+L: `load_x`=0, with `c_out`=coef[L-1..0].
  - T+L+1: `load_x`=1.
- Without flush: `s_ready`=1 from T+L+1.
- With flush: `x_out`=0 and `s_ready`=0 for T+L+1..T+2L, then `s_ready`=1 from T+2L+1.
- Sample accepted at edge k: it appears on `x_out` from k+1. Its `y_valid` is high at k+1+FIR_LAT, if qualified.
- `busy` rises at T+1 and falls the cycle after `stop` is sampled.

## Configuration
- `FIR_LOADER_FLUSH_EN` defined:
  - FLUSH state included, driving L zero samples after LOAD.
  - `warm` is preset to L on FLUSH exit, so the first accepted sample is already qualified for `y_valid`.
- Undefined:
  - No FLUSH state; LOAD goes straight to RUN.
  - The first L-1 accepted samples after a load give `y_valid`=0.

## Structure
- Shared package `fir_pkg`:
  - W1 and L defaults.
  - State enum `loader_state_t` (IDLE, LOAD, FLUSH, RUN).
  - Counter width constant `CNT_W = $clog2(L+1)`.
- One sub-module, `fir_coef_bank`: L×W1 register file with one synchronous write port and one combinational read port. The read address comes from the LOAD counter.

## Test plan
- Write coef[i]=i+1 (i=0..14), then pulse `start` → `load_x` low for exactly 15 cycles. `c_out` sequence 15,14,…,1, then `load_x`=1.
- Flush undefined, stream samples 1..20 with `s_valid` constant, FIR_LAT=1 → `y_valid`=0 for samples 1..14 and 1 for samples 15..20, each at accept+2.
- `FIR_LOADER_FLUSH_EN` defined → 15 cycles of `x_out`=0 with `s_ready`=0 after LOAD. The first sample then gives `y_valid`=1.
- `s_valid` gapped (every other cycle) in RUN → `x_out`=0 in the gap cycles and `y_valid` only on real samples.
- `cfg_we` during RUN with `cfg_addr`=3, `cfg_data`=99, then `start` → reload still shows the old coef[3]=4. A write at `cfg_addr`=15 in IDLE has no effect.
- `stop`+`start` together in RUN → IDLE next cycle. `reset`=0 mid-LOAD → all outputs take their reset values at the next edge.
